// File: rtl/invader_bombs.sv
// invader_bombs: invader-side projectiles. Holds up to NUM_BOMBS falling bombs,
// drops new ones from living invader columns on a frame cadence, moves them down
// once per frame and flags a strike on the player.
// Optional build macro: BOMB_AIM_EN - start the column scan under the player
// instead of at a pseudo-random column.
module invader_bombs #(
    parameter int unsigned NUM_BOMBS     = 3,
    parameter int unsigned NUM_COLS      = 6,
    parameter int unsigned COL_PITCH     = 32,
    parameter int unsigned INVADERS_H    = 96,
    parameter int unsigned BOMB_W        = 6,
    parameter int unsigned BOMB_H        = 12,
    parameter int unsigned BOMB_STEP     = 2,
    parameter int unsigned FIRE_INTERVAL = 48,
    parameter int unsigned SCREEN_BOTTOM = 470,
    parameter int unsigned PLAYER_Y      = 440,
    parameter int unsigned PLAYER_W      = 32,
    parameter int unsigned PLAYER_H      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    frame,
    input  logic                    enable,
    input  logic [9:0]              invaders_x,
    input  logic [9:0]              invaders_y,
    input  logic [NUM_COLS-1:0]     col_alive,
    input  logic [9:0]              player_x,
    output logic [NUM_BOMBS-1:0]    bomb_active,
    output logic [10*NUM_BOMBS-1:0] bomb_x,
    output logic [10*NUM_BOMBS-1:0] bomb_y,
    output logic                    player_hit
);

    localparam int unsigned POS_W  = 10;
    localparam int unsigned SUM_W  = POS_W + 1;
    localparam int unsigned CNT_W  = (FIRE_INTERVAL > 2) ? $clog2(FIRE_INTERVAL) : 1;
    localparam int unsigned SLOT_W = (NUM_BOMBS > 1) ? $clog2(NUM_BOMBS) : 1;
    localparam int unsigned COL_W  = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;

    logic [7:0]       lfsr;
    logic [CNT_W-1:0] frame_cnt;
    logic [POS_W-1:0] x_q [NUM_BOMBS];
    logic [POS_W-1:0] y_q [NUM_BOMBS];

    logic [NUM_BOMBS-1:0] hit_vec;
    logic [NUM_BOMBS-1:0] retire_vec;
    logic [SUM_W-1:0]     y_sum [NUM_BOMBS];

    logic              free_found;
    logic [SLOT_W-1:0] free_idx;
    logic              col_found;
    int unsigned       start_col;
    int unsigned       scan;
    int unsigned       spawn_col;
    logic [POS_W-1:0]  spawn_x;
    logic [POS_W-1:0]  spawn_y;
`ifdef BOMB_AIM_EN
    logic [SUM_W-1:0]  centre;
    logic [SUM_W-1:0]  aim_q;
`endif

    // Per-slot player overlap test and next-frame position
    always_comb begin
        hit_vec    = '0;
        retire_vec = '0;
        for (int i = 0; i < NUM_BOMBS; i++) begin
            y_sum[i]      = {1'b0, y_q[i]} + SUM_W'(BOMB_STEP);
            retire_vec[i] = (y_sum[i] >= SUM_W'(SCREEN_BOTTOM));
            hit_vec[i]    = bomb_active[i]
                && ({1'b0, x_q[i]} < (SUM_W'(player_x) + SUM_W'(PLAYER_W)))
                && (({1'b0, x_q[i]} + SUM_W'(BOMB_W)) > SUM_W'(player_x))
                && ({1'b0, y_q[i]} < SUM_W'(PLAYER_Y + PLAYER_H))
                && (({1'b0, y_q[i]} + SUM_W'(BOMB_H)) > SUM_W'(PLAYER_Y));
        end
    end

    // Lowest-index idle slot, judged on the registered flags
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < NUM_BOMBS; i++) begin
            if (!free_found && !bomb_active[i]) begin
                free_found = 1'b1;
                free_idx   = SLOT_W'(i);
            end
        end
    end

    // Start column choice, then wrap-around scan for the first living column
    always_comb begin
        start_col = 0;
        scan      = 0;
        spawn_col = 0;
        col_found = 1'b0;
`ifdef BOMB_AIM_EN
        centre = SUM_W'(player_x) + SUM_W'(PLAYER_W / 2);
        aim_q  = '0;
        if (centre >= SUM_W'(invaders_x)) begin
            aim_q = (centre - SUM_W'(invaders_x)) / SUM_W'(COL_PITCH);
            if (32'(aim_q) > NUM_COLS - 1) begin
                start_col = NUM_COLS - 1;
            end else begin
                start_col = 32'(aim_q);
            end
        end
`else
        start_col = 32'(lfsr[2:0]);
        if (start_col >= NUM_COLS) begin
            start_col = start_col - NUM_COLS;
        end
`endif
        for (int k = 0; k < NUM_COLS; k++) begin
            scan = start_col + 32'(k);
            if (scan >= NUM_COLS) begin
                scan = scan - NUM_COLS;
            end
            if (!col_found && col_alive[COL_W'(scan)]) begin
                col_found = 1'b1;
                spawn_col = scan;
            end
        end
        spawn_x = invaders_x + POS_W'(spawn_col * COL_PITCH) + POS_W'((COL_PITCH - BOMB_W) / 2);
        spawn_y = invaders_y + POS_W'(INVADERS_H);
    end

    // State update: LFSR free-runs, everything else only while enabled
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr        <= 8'hA5;
            frame_cnt   <= '0;
            bomb_active <= '0;
            player_hit  <= 1'b0;
            for (int i = 0; i < NUM_BOMBS; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
            end
        end else begin
            lfsr       <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            player_hit <= enable && (|hit_vec);
            if (enable) begin
                for (int i = 0; i < NUM_BOMBS; i++) begin
                    if (hit_vec[i]) begin
                        bomb_active[i] <= 1'b0;
                    end else if (frame && bomb_active[i]) begin
                        if (retire_vec[i]) begin
                            bomb_active[i] <= 1'b0;
                        end else begin
                            y_q[i] <= y_sum[i][POS_W-1:0];
                        end
                    end
                end
                if (frame) begin
                    if (frame_cnt == CNT_W'(FIRE_INTERVAL - 1)) begin
                        frame_cnt <= '0;
                        // The chosen slot is idle, so no move/hit update competes with it
                        if (free_found && col_found) begin
                            bomb_active[free_idx] <= 1'b1;
                            x_q[free_idx]         <= spawn_x;
                            y_q[free_idx]         <= spawn_y;
                        end
                    end else begin
                        frame_cnt <= frame_cnt + CNT_W'(1);
                    end
                end
            end
        end
    end

    // Flatten slot registers onto the renderer-facing buses
    for (genvar g = 0; g < NUM_BOMBS; g++) begin : g_out
        assign bomb_x[POS_W*g +: POS_W] = x_q[g];
        assign bomb_y[POS_W*g +: POS_W] = y_q[g];
    end

endmodule

// File: tb/tb_invader_bombs.sv
// Scoreboard bench for invader_bombs: stimulus pushes expected snapshots tagged
// with the cycle they apply to; a negedge monitor pops and compares them.
module tb_invader_bombs;

    logic        clk         = 1'b0;
    logic        rst         = 1'b1;
    logic        frame       = 1'b0;
    logic        enable      = 1'b1;
    logic [9:0]  invaders_x  = 10'd100;
    logic [9:0]  invaders_y  = 10'd50;
    logic [9:0]  player_x    = 10'd600;
    logic [5:0]  col_alive   = 6'b000100;
    logic [2:0]  bomb_active;
    logic [29:0] bomb_x;
    logic [29:0] bomb_y;
    logic        player_hit;

    invader_bombs #(.FIRE_INTERVAL(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .frame      (frame),
        .enable     (enable),
        .invaders_x (invaders_x),
        .invaders_y (invaders_y),
        .col_alive  (col_alive),
        .player_x   (player_x),
        .bomb_active(bomb_active),
        .bomb_x     (bomb_x),
        .bomb_y     (bomb_y),
        .player_hit (player_hit)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        string       name;
        logic [2:0]  act;
        logic [29:0] x;
        logic [29:0] y;
        logic        hit;
    } exp_t;

    exp_t q[$];
    int   cyc        = 0;
    int   checks     = 0;
    int   passes     = 0;
    int   hits_seen  = 0;
    int   hits_exp   = 0;
    bit   done       = 1'b0;
    bit   final_done = 1'b0;

    logic [7:0] lfsr_m;
    logic [2:0] e_act = '0;
    int         e_x [3];
    int         e_y [3];
    int         e_cnt = 0;
    int         e_col = 2;
    bit         lfsr_mode = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference copy of the pseudo-random source, used to predict start columns
    always @(posedge clk) lfsr_m <= rst ? 8'hA5 : {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};

    task automatic push(input string nm, input bit h);
        exp_t e;
        e.cyc  = cyc + 1;
        e.name = nm;
        e.act  = e_act;
        e.x    = {10'(e_x[2]), 10'(e_x[1]), 10'(e_x[0])};
        e.y    = {10'(e_y[2]), 10'(e_y[1]), 10'(e_y[0])};
        e.hit  = h;
        q.push_back(e);
    endtask

    // Column reached when col_alive = 6'b100001
    function automatic int pick_col();
        int s;
`ifdef BOMB_AIM_EN
        int c;
        c = int'(player_x) + 16;
        if (c < int'(invaders_x)) s = 0;
        else begin
            s = (c - int'(invaders_x)) / 32;
            if (s > 5) s = 5;
        end
`else
        s = int'(lfsr_m[2:0]);
        if (s >= 6) s = s - 6;
`endif
        return (s == 0) ? 0 : 5;
    endfunction

    // One enabled frame pulse plus one idle cycle; hit_slot >= 0 expects a strike after the move
    task automatic frame_step(input string nm, input int hit_slot);
        int free;
        int yn;
        int col;
        free = -1;
        col  = lfsr_mode ? pick_col() : e_col;
        for (int i = 0; i < 3; i++) if (!e_act[i] && free < 0) free = i;
        for (int i = 0; i < 3; i++) begin
            if (e_act[i]) begin
                yn = e_y[i] + 2;
                if (yn >= 470) e_act[i] = 1'b0;
                else e_y[i] = yn;
            end
        end
        if (e_cnt == 3) begin
            e_cnt = 0;
            if (free >= 0 && col >= 0) begin
                e_act[free] = 1'b1;
                e_x[free]   = (int'(invaders_x) + col * 32 + 13) % 1024;
                e_y[free]   = (int'(invaders_y) + 96) % 1024;
            end
        end else begin
            e_cnt++;
        end
        frame = 1'b1;
        push(nm, 1'b0);
        @(negedge clk);
        frame = 1'b0;
        if (hit_slot >= 0) begin
            e_act[hit_slot] = 1'b0;
            hits_exp++;
            push({nm, "_pulse"}, 1'b1);
        end else begin
            push({nm, "_idle"}, 1'b0);
        end
        @(negedge clk);
    endtask

    task automatic do_reset(input string nm);
        rst   = 1'b1;
        e_act = '0;
        e_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            e_x[i] = 0;
            e_y[i] = 0;
        end
        push(nm, 1'b0);
        @(negedge clk);
        push(nm, 1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: compare every due snapshot, count strike pulses, run final checks
    always @(negedge clk) begin
        exp_t e;
        if (player_hit === 1'b1) hits_seen++;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            checks++;
            if (e.cyc == cyc && bomb_active === e.act && bomb_x === e.x && bomb_y === e.y && player_hit === e.hit)
                passes++;
            else
                $display("FAIL %s cyc=%0d: got act=%b x=%0d,%0d,%0d y=%0d,%0d,%0d hit=%b; want act=%b x=%0d,%0d,%0d y=%0d,%0d,%0d hit=%b",
                         e.name, cyc, bomb_active, bomb_x[9:0], bomb_x[19:10], bomb_x[29:20],
                         bomb_y[9:0], bomb_y[19:10], bomb_y[29:20], player_hit,
                         e.act, e.x[9:0], e.x[19:10], e.x[29:20], e.y[9:0], e.y[19:10], e.y[29:20], e.hit);
        end
        if (done && !final_done) begin
            checks++;
            if (hits_seen == hits_exp) passes++;
            else $display("FAIL hit_count: got %0d pulses, want %0d", hits_seen, hits_exp);
            checks++;
            if (q.size() == 0) passes++;
            else $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
            final_done = 1'b1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            e_x[i] = 0;
            e_y[i] = 0;
        end
        @(negedge clk);
        do_reset("reset_init");

        // Four frames to the first spawn: column 2 -> x=177, y=146 in slot 0
        e_col = 2;
        for (int f = 0; f < 4; f++) frame_step("spawn_col2", -1);

        // No living columns for three intervals: bomb keeps falling, nothing spawns
        col_alive = 6'b000000;
        e_col     = -1;
        for (int f = 0; f < 12; f++) frame_step("no_alive", -1);

        // Disabled: frames ignored, positions and counter frozen
        enable = 1'b0;
        for (int f = 0; f < 3; f++) begin
            frame = 1'b1;
            push("frozen", 1'b0);
            @(negedge clk);
            frame = 1'b0;
            push("frozen_idle", 1'b0);
            @(negedge clk);
        end
        enable = 1'b1;

        // Start column from the pseudo-random source, scan wraps to column 0 or 5
        col_alive  = 6'b100001;
        invaders_x = 10'd200;
        lfsr_mode  = 1'b1;
        for (int f = 0; f < 4; f++) frame_step("lfsr_spawn", -1);
        lfsr_mode = 1'b0;

        // Fill slot 2, then a spawn tick with every slot busy
        col_alive  = 6'b000100;
        invaders_x = 10'd300;
        e_col      = 2;
        for (int f = 0; f < 4; f++) frame_step("spawn_slot2", -1);
        for (int f = 0; f < 4; f++) frame_step("all_full", -1);

        do_reset("reset_mid");

        // Slot 0 starts low above the player, slots 1/2 elsewhere
        invaders_x = 10'd100;
        invaders_y = 10'd308;
        player_x   = 10'd170;
        for (int f = 0; f < 4; f++) frame_step("spawn_low", -1);
        invaders_x = 10'd200;
        invaders_y = 10'd50;
        for (int f = 0; f < 4; f++) frame_step("spawn_s1", -1);
        invaders_x = 10'd300;
        for (int f = 0; f < 4; f++) frame_step("spawn_s2", -1);
        for (int f = 0; f < 4; f++) frame_step("approach", -1);
        frame_step("strike_y430", 0);

        // Freed slot 0 refilled near the bottom, then retired at 470
        player_x   = 10'd600;
        invaders_x = 10'd100;
        invaders_y = 10'd370;
        for (int f = 0; f < 3; f++) frame_step("refill", -1);
        frame_step("bottom_468", -1);
        frame_step("bottom_retire", -1);
        for (int f = 0; f < 3; f++) begin
            push("quiet", 1'b0);
            @(negedge clk);
        end

        done = 1'b1;
        @(negedge clk);
        @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
